// File: rtl/icache_pkg.sv
// Shared geometry, bus constants and FSM encodings for the direct-mapped
// instruction cache.
package icache_pkg;

  localparam int BUS_DATA_WIDTH = 64;
  localparam int BUS_TAG_WIDTH  = 13;
  localparam int LINE_BYTES     = 64;
  localparam int NUM_SETS       = 64;
  localparam int ADDR_WIDTH     = 64;

  localparam int OFFSET_WIDTH   = $clog2(LINE_BYTES);
  localparam int INDEX_WIDTH    = $clog2(NUM_SETS);
  localparam int TAG_WIDTH      = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int BEATS_PER_LINE = LINE_BYTES / (BUS_DATA_WIDTH / 8);
  localparam int WORD_SEL_WIDTH = OFFSET_WIDTH - 2;

  localparam logic [BUS_TAG_WIDTH-1:0] REQTAG_READ_MEM = 13'h1100;

  typedef logic [$clog2(BEATS_PER_LINE)-1:0] beat_cnt_t;
  typedef logic [INDEX_WIDTH-1:0]            index_t;
  typedef logic [TAG_WIDTH-1:0]              tag_t;
  typedef logic [2:0]                        state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_LOOKUP    = 3'd1;
  localparam state_t ST_MISS_REQ  = 3'd2;
  localparam state_t ST_FILL      = 3'd3;
  localparam state_t ST_FILL_DONE = 3'd4;

  localparam beat_cnt_t LAST_BEAT = beat_cnt_t'(BEATS_PER_LINE - 1);

endpackage

// File: rtl/icache_if.sv
// Fetch-side and system-bus-side bundles of the instruction cache.
// master is the side that issues requests on each bundle.
interface icache_fetch_if;
  import icache_pkg::*;

  logic                      ic_req;
  logic [ADDR_WIDTH-1:0]     ic_addr;
  logic                      ic_invalidate;
  logic                      ic_read_done;
  logic                      ic_data_valid;
  logic [BUS_DATA_WIDTH-1:0] ic_instr;

  modport master (output ic_req, ic_addr, ic_invalidate,
                  input  ic_read_done, ic_data_valid, ic_instr);
  modport slave  (input  ic_req, ic_addr, ic_invalidate,
                  output ic_read_done, ic_data_valid, ic_instr);
endinterface

interface icache_bus_if;
  import icache_pkg::*;

  logic                      bus_reqcyc;
  logic [ADDR_WIDTH-1:0]     bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_reqack;
  logic                      bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
  logic                      bus_respack;

  modport master (output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
                  input  bus_reqack, bus_respcyc, bus_resp, bus_resptag);
  modport slave  (input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
                  output bus_reqack, bus_respcyc, bus_resp, bus_resptag);
endinterface

// File: rtl/icache_array.sv
// Tag, valid and data storage: one combinational read port, one bus-beat
// write port, one tag write (which also sets the line valid) and a bulk clear.
module icache_array
  import icache_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  index_t                    idx,
  input  logic [WORD_SEL_WIDTH-1:0] rd_word,
  output logic                      rd_valid,
  output tag_t                      rd_tag,
  output logic [31:0]               rd_instr,
  input  logic                      wr_en,
  input  beat_cnt_t                 wr_beat,
  input  logic [BUS_DATA_WIDTH-1:0] wr_data,
  input  logic                      tag_we,
  input  tag_t                      tag_wdata,
  input  logic                      line_inv,
  input  logic                      clear_all
);

  localparam int DATA_DEPTH = NUM_SETS * BEATS_PER_LINE;

  logic [BUS_DATA_WIDTH-1:0] data_mem [DATA_DEPTH];
  tag_t                      tag_mem  [NUM_SETS];
  logic [NUM_SETS-1:0]       valid;
  logic [BUS_DATA_WIDTH-1:0] rd_beat;

  assign rd_beat  = data_mem[{idx, rd_word[WORD_SEL_WIDTH-1:1]}];
  assign rd_instr = rd_word[0] ? rd_beat[63:32] : rd_beat[31:0];
  assign rd_valid = valid[idx];
  assign rd_tag   = tag_mem[idx];

  // NOTE: data and tag RAMs carry no reset; the valid bits alone make stale
  // contents unreachable.
  always_ff @(posedge clk) begin
    if (wr_en)  data_mem[{idx, wr_beat}] <= wr_data;
    if (tag_we) tag_mem[idx]             <= tag_wdata;
  end

  // NOTE: sequential state is always updated with non-blocking assignments.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       valid      <= '0;
    else if (clear_all) valid      <= '0;
    else if (tag_we)    valid[idx] <= 1'b1;
    else if (line_inv)  valid[idx] <= 1'b0;
  end

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: lookup FSM, line refill over the
// system bus, and held instruction output for the fetch stage.
module icache_ctrl
  import icache_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  icache_fetch_if.slave fetch,
  icache_bus_if.master  bus
);

  state_t                    state;
  logic [ADDR_WIDTH-1:0]     addr_q;
  beat_cnt_t                 beat_cnt;
  logic                      inv_pending;
  logic                      data_valid_q;
  logic [31:0]               instr_q;

  index_t                    idx;
  tag_t                      tag;
  logic [WORD_SEL_WIDTH-1:0] word_sel;
  logic                      rd_valid;
  tag_t                      rd_tag;
  logic [31:0]               rd_instr;
  logic                      hit;
  logic                      deliver;
  logic                      beat_ok;
  logic                      clear_all;
  logic                      line_inv;
  logic                      unused_addr_bits;

  assign idx              = addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
  assign tag              = addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign word_sel         = addr_q[OFFSET_WIDTH-1:2];
  assign unused_addr_bits = ^addr_q[1:0];

  assign hit       = rd_valid && (rd_tag == tag);
  assign deliver   = ((state == ST_LOOKUP) && hit) || (state == ST_FILL_DONE);
  assign beat_ok   = (state == ST_FILL) && bus.bus_respcyc &&
                     (bus.bus_resptag == REQTAG_READ_MEM);
  assign clear_all = (state == ST_IDLE) && (fetch.ic_invalidate || inv_pending);
  // The victim line goes invalid as soon as the miss is known, so a partial
  // refill can never be mistaken for a hit.
  assign line_inv  = (state == ST_LOOKUP) && !hit;

  icache_array u_array (
    .clk       (clk),
    .reset_n   (reset_n),
    .idx       (idx),
    .rd_word   (word_sel),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_instr  (rd_instr),
    .wr_en     (beat_ok),
    .wr_beat   (beat_cnt),
    .wr_data   (bus.bus_resp),
    .tag_we    (state == ST_FILL_DONE),
    .tag_wdata (tag),
    .line_inv  (line_inv),
    .clear_all (clear_all)
  );

  // The delivery cycle bypasses the holding register so hits return in one cycle.
  assign fetch.ic_read_done  = deliver;
  assign fetch.ic_data_valid = deliver | data_valid_q;
  assign fetch.ic_instr      = {32'b0, deliver ? rd_instr : instr_q};

  assign bus.bus_reqcyc  = (state == ST_MISS_REQ);
  assign bus.bus_req     = bus.bus_reqcyc ? {addr_q[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}}
                                          : '0;
  assign bus.bus_reqtag  = bus.bus_reqcyc ? REQTAG_READ_MEM : '0;
  // Beats are always drained, including stragglers of a fill cut short by reset.
  assign bus.bus_respack = bus.bus_respcyc & reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      addr_q       <= '0;
      beat_cnt     <= '0;
      inv_pending  <= 1'b0;
      data_valid_q <= 1'b0;
      instr_q      <= '0;
    end else begin
      if (deliver) begin
        instr_q      <= rd_instr;
        data_valid_q <= 1'b1;
      end
      if ((state != ST_IDLE) && fetch.ic_invalidate) inv_pending <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (clear_all) begin
            inv_pending <= 1'b0;
          end else if (fetch.ic_req) begin
            addr_q       <= fetch.ic_addr;
            data_valid_q <= 1'b0;
            state        <= ST_LOOKUP;
          end
        end
        ST_LOOKUP:    state <= hit ? ST_IDLE : ST_MISS_REQ;
        ST_MISS_REQ: begin
          if (bus.bus_reqack) begin
            beat_cnt <= '0;
            state    <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (beat_ok) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) state <= ST_FILL_DONE;
          end
        end
        ST_FILL_DONE: state <= ST_IDLE;
        default:      state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Randomized scoreboard bench for icache_ctrl: a line-granular cache model
// predicts hit/miss and instruction words; a bus model serves refills.
module tb_icache_ctrl;
  import icache_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  icache_fetch_if fetch_bus ();
  icache_bus_if   sys_bus ();

  icache_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .fetch   (fetch_bus),
    .bus     (sys_bus)
  );

  typedef struct {
    logic [31:0] instr;
    int          req_total;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb_q[$];
  logic [63:0] line_q[$];
  bit          model_valid [64];
  logic [51:0] model_tag   [64];
  int          model_reqs = 0;
  int          bus_req_count = 0;
  bit          force_stall = 0;
  bit          abort_mode = 0;
  bit          paused = 0;
  bit          bus_busy = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Backing memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] word32(input logic [63:0] a);
    return ((a[31:0] ^ a[63:32]) * 32'h9E37_79B1) ^ 32'hC0DE_1234;
  endfunction

  function automatic logic [63:0] beat_data(input logic [63:0] line, input int b);
    logic [63:0] base;
    base = line + 64'(8 * b);
    return {word32(base + 64'd4), word32(base)};
  endfunction

  task automatic model_clear();
    foreach (model_valid[i]) model_valid[i] = 1'b0;
  endtask

  task automatic model_access(input logic [63:0] a, output bit miss);
    int i;
    i = int'(a[11:6]);
    miss = !(model_valid[i] && model_tag[i] == a[63:12]);
    if (miss) begin
      model_reqs++;
      line_q.push_back({a[63:6], 6'b0});
      model_valid[i] = 1'b1;
      model_tag[i]   = a[63:12];
    end
    sb_q.push_back('{word32({a[63:2], 2'b00}), model_reqs});
  endtask

  // inv_mode: 0 none, 1 invalidate alongside the request, 2 pulse mid-refill.
  task automatic issue(input logic [63:0] a, input int inv_mode, output int lat);
    bit miss;
    if (inv_mode == 1) model_clear();
    model_access(a, miss);
    fetch_bus.ic_req        = 1'b1;
    fetch_bus.ic_addr       = a;
    fetch_bus.ic_invalidate = (inv_mode == 1);
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      fetch_bus.ic_invalidate = (inv_mode == 2) && miss && (lat == 3);
      if (fetch_bus.ic_read_done === 1'b1) break;
      if (lat > 400) begin
        check("read_done_timeout", 64'd0, 64'd1);
        break;
      end
    end
    fetch_bus.ic_req        = 1'b0;
    fetch_bus.ic_invalidate = 1'b0;
    if (inv_mode == 2 && miss) model_clear();
  endtask

  task automatic serve();
    logic [63:0] line;
    int          good;
    int          d;
    bus_busy = 1'b1;
    line = sys_bus.bus_req;
    check("req_tag", 64'(sys_bus.bus_reqtag), 64'(REQTAG_READ_MEM));
    if (line_q.size() == 0) check("unexpected_bus_req", 64'd1, 64'd0);
    else                    check("req_line", line, line_q.pop_front());
    bus_req_count++;
    d = force_stall ? 5 : $urandom_range(0, 3);
    repeat (d) begin
      @(negedge clk);
      check("reqcyc_held", 64'(sys_bus.bus_reqcyc), 64'd1);
      check("req_held", sys_bus.bus_req, line);
    end
    sys_bus.bus_reqack = 1'b1;
    @(negedge clk);
    sys_bus.bus_reqack = 1'b0;
    good = 0;
    while (good < 8) begin
      if (abort_mode && good == 3) begin
        sys_bus.bus_respcyc = 1'b0;
        paused = 1'b1;
        wait (paused == 1'b0);
      end
      if (force_stall || $urandom_range(0, 3) == 0) begin
        sys_bus.bus_respcyc = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      if ($urandom_range(0, 5) == 0) begin
        sys_bus.bus_respcyc = 1'b1;
        sys_bus.bus_resptag = 13'h0BAD;
        sys_bus.bus_resp    = {$urandom, $urandom};
        #1 check("respack_badtag", 64'(sys_bus.bus_respack), 64'd1);
        @(negedge clk);
      end
      sys_bus.bus_respcyc = 1'b1;
      sys_bus.bus_resptag = REQTAG_READ_MEM;
      sys_bus.bus_resp    = beat_data(line, good);
      #1 check("respack", 64'(sys_bus.bus_respack), 64'd1);
      @(negedge clk);
      good++;
    end
    sys_bus.bus_respcyc = 1'b0;
    sys_bus.bus_resptag = '0;
    bus_busy = 1'b0;
  endtask

  initial begin : bus_model
    sys_bus.bus_reqack  = 1'b0;
    sys_bus.bus_respcyc = 1'b0;
    sys_bus.bus_resp    = '0;
    sys_bus.bus_resptag = '0;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) continue;
      if (sys_bus.bus_reqcyc === 1'b1) begin
        serve();
      end else if ($urandom_range(0, 15) == 0) begin
        sys_bus.bus_respcyc = 1'b1;
        sys_bus.bus_resptag = REQTAG_READ_MEM;
        sys_bus.bus_resp    = {$urandom, $urandom};
        #1 check("respack_stray", 64'(sys_bus.bus_respack), 64'd1);
        @(negedge clk);
        sys_bus.bus_respcyc = 1'b0;
      end
    end
  end

  initial begin : monitor
    exp_t        e;
    logic [31:0] last = '0;
    forever begin
      @(negedge clk);
      if (fetch_bus.ic_read_done === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_read_done", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("instr", fetch_bus.ic_instr, {32'b0, e.instr});
          check("bus_req_count", 64'(bus_req_count), 64'(e.req_total));
          check("data_valid_on_done", 64'(fetch_bus.ic_data_valid), 64'd1);
          last = e.instr;
        end
      end else if (fetch_bus.ic_data_valid === 1'b1) begin
        check("instr_hold", fetch_bus.ic_instr, {32'b0, last});
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_read_done"},  64'(fetch_bus.ic_read_done), 64'd0);
    check({tag, "_data_valid"}, 64'(fetch_bus.ic_data_valid), 64'd0);
    check({tag, "_instr"},      fetch_bus.ic_instr, 64'd0);
    check({tag, "_reqcyc"},     64'(sys_bus.bus_reqcyc), 64'd0);
    check({tag, "_bus_req"},    sys_bus.bus_req, 64'd0);
    check({tag, "_reqtag"},     64'(sys_bus.bus_reqtag), 64'd0);
    check({tag, "_respack"},    64'(sys_bus.bus_respack), 64'd0);
  endtask

  initial begin : driver
    int          lat;
    int          n;
    bit          miss;
    logic [51:0] tag_pool [4];
    tag_pool[0] = 52'h1;
    tag_pool[1] = 52'h2;
    tag_pool[2] = 52'h3;
    tag_pool[3] = 52'hF_FFFF_FFFF_FFF0;

    fetch_bus.ic_req        = 1'b0;
    fetch_bus.ic_addr       = '0;
    fetch_bus.ic_invalidate = 1'b0;
    model_clear();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    issue(64'h1000, 0, lat);
    @(negedge clk);
    issue(64'h100C, 0, lat);
    check("hit_latency", 64'(lat), 64'd1);
    issue(64'h2000, 0, lat);
    issue(64'h1000, 0, lat);
    @(negedge clk);
    issue(64'h1004, 1, lat);

    force_stall = 1'b1;
    issue(64'h5_0080, 0, lat);
    force_stall = 1'b0;

    // Reset arrives after three beats of a refill.
    model_access(64'h3040, miss);
    abort_mode              = 1'b1;
    fetch_bus.ic_req        = 1'b1;
    fetch_bus.ic_addr       = 64'h3040;
    n = 0;
    while (!paused && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached", 64'(paused), 64'd1);
    fetch_bus.ic_req = 1'b0;
    reset_n = 1'b0;
    #1 check_outputs_zero("midfill_reset");
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    sb_q.delete();
    abort_mode = 1'b0;
    paused     = 1'b0;
    n = 0;
    while (bus_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_drain", 64'(bus_busy), 64'd0);
    @(negedge clk);
    issue(64'h3040, 0, lat);
    issue(64'h3048, 0, lat);

    for (int k = 0; k < 250; k++) begin
      logic [63:0] a;
      int          r;
      int          mode;
      a = {tag_pool[$urandom_range(0, 3)],
           ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00};
      r = $urandom_range(0, 19);
      mode = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(a, mode, lat);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    check("bus_lines_drained", 64'(line_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
